// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC types for the router output stage.
// Holds the flit format, the flit label enum, the VC count and index type,
// the width of the per-VC allocation guard counter and the per-source states.
package noc_pkg;

  localparam int VC_NUM        = 2;
  localparam int VC_IDX_W      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int ALLOC_GUARD_W = 4;
  localparam int FLIT_DATA_W   = 32;

  typedef logic [VC_IDX_W-1:0] vc_idx_t;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t             flit_label;
    vc_idx_t                 vc_id;
    logic [FLIT_DATA_W-1:0]  data;
  } flit_t;

  // Per-source state: IDLE holds no downstream VC, ACTIVE holds one.
  localparam logic [0:0] SRC_IDLE   = 1'b0;
  localparam logic [0:0] SRC_ACTIVE = 1'b1;

  // A flit that opens a packet and may therefore request a VC.
  function automatic logic isHead(input flit_label_t label);
    return (label == HEAD) || (label == HEADTAIL);
  endfunction

  // A flit that closes a packet and therefore releases its VC.
  function automatic logic isTail(input flit_label_t label);
    return (label == TAIL) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/router2router.sv
// router2router: point-to-point link between two routers.
// The upstream side drives flits; the downstream side reports per-VC
// on/off flow control and whether each VC is free for a new packet.
interface router2router;
  import noc_pkg::*;

  flit_t               data;
  logic                is_valid;
  logic [VC_NUM-1:0]   is_on_off;
  logic [VC_NUM-1:0]   is_allocatable;

  modport upstream   (output data, is_valid, input  is_on_off, is_allocatable);
  modport downstream (input  data, is_valid, output is_on_off, is_allocatable);

endinterface

// File: rtl/link_vc_scheduler_rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with a one-hot grant.
// The search starts at the pointer; when 'advance' is high the pointer
// moves to one past the current winner at the next clock edge.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_nextPtr;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Pick the first requester at or after the pointer, wrapping around
  always_comb begin
    grant     = '0;
    w_nextPtr = r_ptr;
    w_idx     = '0;
    w_found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
        w_nextPtr    = PTR_W'(((int'(r_ptr) + k) % N + 1) % N);
      end
    end
  end

  // Move the pointer past the winner only when the grant is consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= w_nextPtr;
    end
  end

endmodule

// File: rtl/link_vc_scheduler.sv
// link_vc_scheduler: shares one router-to-router link among VC_NUM source
// queues. Head flits are given the lowest free downstream VC (one allocation
// per cycle, round-robin among requesters), then sources holding a VC with
// downstream permission compete flit-by-flit for the link. The chosen flit is
// rewritten with its downstream vc_id and registered onto the link.
// Optional feature macro: LINK_VC_SCHED_FASTPATH_EN lets a source compete for
// the link in the same cycle its VC is allocated.
module link_vc_scheduler
  import noc_pkg::*;
#(
  parameter int ALLOC_GUARD = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  flit_t              src_data [VC_NUM],
  input  logic [VC_NUM-1:0]  src_valid,
  output logic [VC_NUM-1:0]  src_ready,
  router2router.upstream     link
);

  logic [0:0]               r_srcState [VC_NUM];
  vc_idx_t                  r_dvc      [VC_NUM];
  logic [VC_NUM-1:0]        r_reserved;
  logic [ALLOC_GUARD_W-1:0] r_guard    [VC_NUM];
  flit_t                    r_linkData;
  logic                     r_linkValid;

  logic [VC_NUM-1:0] w_vcFree;
  logic              w_anyFree;
  vc_idx_t           w_freeVc;
  logic [VC_NUM-1:0] w_vaReq;
  logic [VC_NUM-1:0] w_vaGrant;
  logic              w_vaValid;
  logic              w_protoErr;
  vc_idx_t           w_effDvc [VC_NUM];
  logic [VC_NUM-1:0] w_saReq;
  logic [VC_NUM-1:0] w_saGrant;
  logic              w_saValid;
  vc_idx_t           w_saVc;
  flit_t             w_saFlit;
  logic              w_saTail;

  // Find the free VCs and the lowest-index one among them
  always_comb begin
    w_vcFree  = '0;
    w_anyFree = 1'b0;
    w_freeVc  = '0;
    for (int v = VC_NUM - 1; v >= 0; v--) begin
      w_vcFree[v] = link.is_allocatable[v] & ~r_reserved[v] & (r_guard[v] == '0);
      if (w_vcFree[v]) begin
        w_anyFree = 1'b1;
        w_freeVc  = vc_idx_t'(v);
      end
    end
  end

  // Idle sources with a head flit request a VC; body/tail at idle is an error
  always_comb begin
    w_vaReq    = '0;
    w_protoErr = 1'b0;
    for (int i = 0; i < VC_NUM; i++) begin
      if ((r_srcState[i] == SRC_IDLE) && src_valid[i]) begin
        w_vaReq[i] = isHead(src_data[i].flit_label) & w_anyFree;
        if (!isHead(src_data[i].flit_label)) begin
          w_protoErr = 1'b1;
        end
      end
    end
  end

  rr_arbiter #(.N(VC_NUM)) u_vaArb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_vaReq),
    .advance (w_vaValid),
    .grant   (w_vaGrant)
  );

  assign w_vaValid = |w_vaGrant;

  // Sources holding a VC whose downstream is on compete for the link
  always_comb begin
    w_saReq = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      w_effDvc[i] = r_dvc[i];
      w_saReq[i]  = (r_srcState[i] == SRC_ACTIVE) & src_valid[i] & link.is_on_off[r_dvc[i]];
`ifdef LINK_VC_SCHED_FASTPATH_EN
      if (w_vaGrant[i]) begin
        w_effDvc[i] = w_freeVc;
        w_saReq[i]  = link.is_on_off[w_freeVc];
      end
`endif
    end
  end

  rr_arbiter #(.N(VC_NUM)) u_saArb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_saReq),
    .advance (w_saValid),
    .grant   (w_saGrant)
  );

  assign w_saValid = |w_saGrant;
  assign src_ready = w_saGrant;

  // Mux the granted flit and stamp it with its downstream VC
  always_comb begin
    w_saVc   = '0;
    w_saFlit = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      if (w_saGrant[i]) begin
        w_saVc   = w_effDvc[i];
        w_saFlit = src_data[i];
      end
    end
    w_saFlit.vc_id = w_saVc;
    w_saTail       = w_saValid & isTail(w_saFlit.flit_label);
  end

  // Track source ownership, VC reservations and post-release guard timers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VC_NUM; i++) begin
        r_srcState[i] <= SRC_IDLE;
        r_dvc[i]      <= '0;
        r_guard[i]    <= '0;
      end
      r_reserved <= '0;
    end else begin
      for (int i = 0; i < VC_NUM; i++) begin
        if (w_vaGrant[i]) begin
          r_srcState[i] <= SRC_ACTIVE;
          r_dvc[i]      <= w_freeVc;
        end
        if (w_saGrant[i] && w_saTail) begin
          r_srcState[i] <= SRC_IDLE;
        end
        if (r_guard[i] != '0) begin
          r_guard[i] <= r_guard[i] - 1'b1;
        end
      end
      if (w_vaValid) begin
        r_reserved[w_freeVc] <= 1'b1;
      end
      if (w_saTail) begin
        r_reserved[w_saVc] <= 1'b0;
        r_guard[w_saVc]    <= ALLOC_GUARD_W'(ALLOC_GUARD);
      end
    end
  end

  // Register the granted flit onto the link; data holds on idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_linkValid <= 1'b0;
      r_linkData  <= '0;
    end else begin
      r_linkValid <= w_saValid;
      if (w_saValid) begin
        r_linkData <= w_saFlit;
      end
    end
  end

  assign link.data     = r_linkData;
  assign link.is_valid = r_linkValid;

  // Flag body/tail flits presented by a source that holds no VC
  always @(posedge clk) begin
    if (!rst) begin
      assert (!w_protoErr)
        else $warning("link_vc_scheduler: body/tail flit at a source holding no VC");
    end
  end

endmodule
